flappy_game_ctrl: RTL and testbench
===================================

FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset reset, asynchronous, active-high.
REQ-002 Parameter TICK_DIV, 25000000, clk cycles per game tick at level 0.
REQ-003 Parameter TICK_STEP, 4000000, tick-period reduction per level; TICK_DIV SHALL exceed 3*TICK_STEP.
REQ-004 Parameter LEVEL_PTS, 5, pipes passed per level increment.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 start_btn  in  1  start/restart button, already synchronized and debounced, level.
REQ-008 up_btn  in  1  flap button, already synchronized and debounced, level.
REQ-009 bird_over  in  1  boundary-collision flag from the bird motion FSM, level.
REQ-010 pipe_hit  in  1  obstacle-collision flag, level.
REQ-011 pipe_pass  in  1  one-cycle pulse when the bird clears a pipe.
REQ-012 bird_rst  out  1  reset to bird motion FSM, registered.
REQ-013 bird_cont  out  1  one-cycle game-tick advance pulse to bird FSM.
REQ-014 bird_up  out  1  flap request, valid when bird_cont=1.
REQ-015 state  out  2  IDLE=00, PLAY=01, OVER=10.
REQ-016 score  out  8  current score, two packed BCD digits.
REQ-017 best  out  8  best score since reset, two packed BCD digits.
REQ-018 level  out  2  speed level 0..3.
REQ-019 game_over  out  1  high in OVER.

Function
REQ-020 start_btn and up_btn SHALL be edge-detected with registered previous values; a press is prev=0, current=1.
REQ-021 IDLE: bird_rst=1, bird_cont=0, tick counter held at reload value; start press -> PLAY next cycle.
REQ-022 Entering PLAY SHALL clear score, level, pass counter and up latch and reload the tick counter; bird_rst=0 from the first PLAY cycle.
REQ-023 PLAY: down-counter reloads with TICK_DIV - level*TICK_STEP - 1; when it reaches 0, bird_cont=1 for exactly that cycle and the counter reloads.
REQ-024 A level change SHALL take effect only at the next reload, never mid-count.
REQ-025 Up latch SHALL set on any up press in PLAY; bird_up = up latch AND bird_cont; latch clears at the edge ending a bird_cont cycle unless a new press occurs in that same cycle, in which case it stays set.
REQ-026 Multiple presses between ticks SHALL produce a single bird_up.
REQ-027 pipe_pass in PLAY SHALL increment score in BCD (09->10, 99 saturates) and the pass counter; when the pass counter reaches LEVEL_PTS it clears and level increments, saturating at 3.
REQ-028 bird_over=1 or pipe_hit=1 in PLAY -> OVER next cycle; a coincident pipe_pass SHALL be ignored.
REQ-029 On PLAY->OVER transition best SHALL load score if score > best (packed BCD compared as unsigned binary).
REQ-030 OVER: game_over=1, bird_cont=0, score/level/best held, bird_rst=0 (bird remains in its dead state); start press -> IDLE.
REQ-031 A start press in PLAY SHALL be ignored; up presses in IDLE and OVER SHALL be ignored.
REQ-032 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path except none.

Reset
REQ-033 reset SHALL force state=IDLE, bird_rst=1, bird_cont=0, bird_up=0, score=0, best=0, level=0, game_over=0, pass counter and up latch 0, tick counter=TICK_DIV-1.
REQ-034 Button previous-value registers SHALL reset to 1 so a button held through reset release does not register a press.
REQ-035 Reset asserted mid-PLAY SHALL abort immediately; best SHALL also clear.

Verification (TICK_DIV=8, TICK_STEP=2, LEVEL_PTS=2)
REQ-036 Reset, start press -> state 01 next cycle, bird_rst 0, first bird_cont 8 cycles after PLAY entry, then every 8 cycles.
REQ-037 Three up presses between two ticks -> bird_up=1 only on the next bird_cont cycle; following tick bird_up=0.
REQ-038 Two pipe_pass pulses -> score 02, level 1, tick spacing becomes 6 cycles from the reload after the change; 8 further passes -> level saturates at 3, spacing 2.
REQ-039 Score 09 then pipe_pass -> 10; score 99 then pipe_pass -> 99.
REQ-040 pipe_hit coincident with pipe_pass at score 03, best 00 -> OVER, score 03, best 03, game_over 1, no further bird_cont; start -> IDLE, bird_rst 1.
REQ-041 start_btn held high across reset release -> remains IDLE until released and pressed again.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// Game controller for a flappy-bird style game: start/play/over sequencing,
// game-tick generation with speed levels, flap latching and BCD scoring.
module flappy_game_ctrl #(
  parameter int TICK_DIV  = 25000000,
  parameter int TICK_STEP = 4000000,
  parameter int LEVEL_PTS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       up_btn,
  input  logic       bird_over,
  input  logic       pipe_hit,
  input  logic       pipe_pass,
  output logic       bird_rst,
  output logic       bird_cont,
  output logic       bird_up,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic [1:0] level,
  output logic       game_over
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam int              PW        = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;
  localparam logic [PW-1:0]   PASS_LAST = PW'(LEVEL_PTS - 1);
  localparam logic [31:0]     TICK_BASE = 32'(TICK_DIV - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = 8'h99;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [1:0] level_inc(input logic [1:0] v);
    logic [1:0] r;
    if (v == 2'd3) begin
      r = 2'd3;
    end else begin
      r = v + 2'd1;
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          start_prev_q, up_prev_q;
  logic [31:0]   tick_q, tick_d;
  logic          up_latch_q, up_latch_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    best_q, best_d;
  logic [1:0]    level_q, level_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          bird_rst_q, bird_rst_d;
  logic          game_over_q, game_over_d;

  logic          start_press_s, up_press_s, cont_s;
  logic [31:0]   reload_s;

  assign start_press_s = start_btn & ~start_prev_q;
  assign up_press_s    = up_btn & ~up_prev_q;
  assign cont_s        = (state_q == ST_PLAY) && (tick_q == 32'd0);
  // Reload is sampled from level_q only at the zero crossing, so a level
  // change never disturbs a count already in progress.
  assign reload_s      = TICK_BASE - (32'(level_q) * 32'(TICK_STEP));

  // Next-state logic for the game FSM, tick counter, flap latch and scoring.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    up_latch_d = up_latch_q;
    score_d    = score_q;
    best_d     = best_q;
    level_d    = level_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE: begin
        tick_d     = TICK_BASE;
        up_latch_d = 1'b0;
        if (start_press_s) begin
          state_d = ST_PLAY;
          score_d = 8'h00;
          level_d = 2'd0;
          pass_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (bird_over || pipe_hit) begin
          state_d    = ST_OVER;
          tick_d     = TICK_BASE;
          up_latch_d = 1'b0;
          if (score_q > best_q) begin
            best_d = score_q;
          end else begin
            best_d = best_q;
          end
        end else begin
          if (cont_s) begin
            tick_d = reload_s;
          end else begin
            tick_d = tick_q - 32'd1;
          end
          // A press in the tick cycle itself keeps the request for the next tick.
          if (up_press_s) begin
            up_latch_d = 1'b1;
          end else if (cont_s) begin
            up_latch_d = 1'b0;
          end else begin
            up_latch_d = up_latch_q;
          end
          if (pipe_pass) begin
            score_d = bcd_inc(score_q);
            if (pass_q == PASS_LAST) begin
              pass_d  = '0;
              level_d = level_inc(level_q);
            end else begin
              pass_d  = pass_q + PW'(1);
              level_d = level_q;
            end
          end else begin
            score_d = score_q;
          end
        end
      end
      ST_OVER: begin
        tick_d     = TICK_BASE;
        up_latch_d = 1'b0;
        if (start_press_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tick_d     = TICK_BASE;
        up_latch_d = 1'b0;
      end
    endcase
    bird_rst_d  = (state_d == ST_IDLE);
    game_over_d = (state_d == ST_OVER);
  end

  // State registers; button history resets high so a held button is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b1;
      up_prev_q    <= 1'b1;
      tick_q       <= TICK_BASE;
      up_latch_q   <= 1'b0;
      score_q      <= 8'h00;
      best_q       <= 8'h00;
      level_q      <= 2'd0;
      pass_q       <= '0;
      bird_rst_q   <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_btn;
      up_prev_q    <= up_btn;
      tick_q       <= tick_d;
      up_latch_q   <= up_latch_d;
      score_q      <= score_d;
      best_q       <= best_d;
      level_q      <= level_d;
      pass_q       <= pass_d;
      bird_rst_q   <= bird_rst_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign best      = best_q;
  assign level     = level_q;
  assign bird_rst  = bird_rst_q;
  assign game_over = game_over_q;
  assign bird_cont = cont_s;
  assign bird_up   = up_latch_q & cont_s;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl with small tick parameters:
// a vector table for the opening game plus hand sequences for corner cases.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0, up_btn = 1'b0, bird_over = 1'b0;
  logic       pipe_hit = 1'b0, pipe_pass = 1'b0;
  logic       bird_rst, bird_cont, bird_up, game_over;
  logic [1:0] state, level;
  logic [7:0] score, best;

  flappy_game_ctrl #(.TICK_DIV(8), .TICK_STEP(2), .LEVEL_PTS(2)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .up_btn(up_btn),
    .bird_over(bird_over), .pipe_hit(pipe_hit), .pipe_pass(pipe_pass),
    .bird_rst(bird_rst), .bird_cont(bird_cont), .bird_up(bird_up),
    .state(state), .score(score), .best(best), .level(level),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        s, u, o, h, p;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    string       nm;
    logic [23:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  // expected output word: {state, score, best, level, cont, up, rst, go}
  function automatic logic [23:0] ex(input logic [1:0] st, input logic [7:0] sc,
                                     input logic [7:0] bs, input logic [1:0] lv,
                                     input logic c, input logic u,
                                     input logic r, input logic g);
    return {st, sc, bs, lv, c, u, r, g};
  endfunction

  function automatic void add(input string nm, input logic s, input logic u,
                              input logic o, input logic h, input logic p,
                              input logic [23:0] e);
    vec_t v;
    v.nm = nm; v.s = s; v.u = u; v.o = o; v.h = h; v.p = p; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic pop_cmp();
    sb_t it;
    logic [23:0] act;
    act = {state, score, best, level, bird_cont, bird_up, bird_rst, game_over};
    n_chk++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h required an expectation", act);
    end else begin
      it = sbq.pop_front();
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %h required %h (st,score,best,lvl,cont,up,rst,go)",
                 it.nm, act, it.exp);
      end
    end
  endtask

  task automatic check_now(input string nm, input logic [23:0] e);
    sb_t it;
    it.nm = nm; it.exp = e;
    sbq.push_back(it);
    pop_cmp();
  endtask

  task automatic cyc(input string nm, input logic s, input logic u, input logic o,
                     input logic h, input logic p, input logic [23:0] e);
    sb_t it;
    @(negedge clk);
    start_btn = s; up_btn = u; bird_over = o; pipe_hit = h; pipe_pass = p;
    it.nm = nm; it.exp = e;
    sbq.push_back(it);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  // n idle cycles in PLAY, with the tick expected only on the last one
  task automatic gap(input string nm, input int n, input logic [7:0] sc,
                     input logic [7:0] bs, input logic [1:0] lv);
    for (int i = 0; i < n; i++) begin
      cyc(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          ex(2'b01, sc, bs, lv, (i == n - 1), 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] idle0;
    idle0 = ex(2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // opening game: first ticks at level 0, start ignored in PLAY, flap latching
    add("idle",          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle0);
    add("up_in_idle",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, idle0);
    add("idle2",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle0);
    add("start",         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add("start_held",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add("play",          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add("start_in_play", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      add("play_wait",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add("tick1",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++)
      add("flap_presses", 1'b0, (i < 6) && (i % 2 == 0), 1'b0, 1'b0, 1'b0,
          ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add("tick2_flap",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++)
      add("play_wait2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    add("tick3_noflap",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now("reset_vals", idle0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].nm, tbl[i].s, tbl[i].u, tbl[i].o, tbl[i].h, tbl[i].p, tbl[i].exp);

    // level 1 after two passes; spacing changes only after the next reload
    cyc("pass1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("pass2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h02, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    gap("old_period_tail", 6, 8'h02, 8'h00, 2'd1);
    gap("period_6", 6, 8'h02, 8'h00, 2'd1);

    // eight more passes: level saturates at 3, count in progress unaffected, 09->10
    cyc("pass3",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h03, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("pass4",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h04, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("pass5",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h05, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("pass6",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h06, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("pass7",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h07, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("no_midcount_change", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h08, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc("pass9",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h09, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("bcd_09_to_10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h10, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    gap("period_2a", 2, 8'h10, 8'h00, 2'd3);
    gap("period_2b", 2, 8'h10, 8'h00, 2'd3);

    // run score up to 98, then to 99 and saturate
    for (int i = 0; i < 88; i++) begin
      @(negedge clk);
      start_btn = 1'b0; up_btn = 1'b0; bird_over = 1'b0; pipe_hit = 1'b0; pipe_pass = 1'b1;
      @(posedge clk);
    end
    cyc("score_98_to_99", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h99, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("score_sat_99",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h99, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));

    // game over at 99, up ignored in OVER, back to IDLE and into a new game
    cyc("hit_over_99",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex(2'b10, 8'h99, 8'h99, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("up_in_over",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(2'b10, 8'h99, 8'h99, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("over_hold",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b10, 8'h99, 8'h99, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("over_to_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 8'h99, 8'h99, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc("idle_hold",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 8'h99, 8'h99, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc("restart",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h99, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("replay",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h99, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // reset mid-PLAY aborts at once and clears best; start held through release
    @(negedge clk);
    reset = 1'b1;
    start_btn = 1'b1;
    #1;
    check_now("reset_mid_play", idle0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("start_held_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle0);
    cyc("start_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle0);
    cyc("start_again",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // collision coincident with a pass at score 03: pass dropped, best updated
    cyc("g_pass1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("g_pass2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h02, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("g_pass3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(2'b01, 8'h03, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("hit_with_pass", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ex(2'b10, 8'h03, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++)
      cyc("over_no_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b10, 8'h03, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("over_start_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 8'h03, 8'h03, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc("idle_release",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b00, 8'h03, 8'h03, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc("play3",           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(2'b01, 8'h00, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("bird_over_keep_best", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(2'b10, 8'h00, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
